// File: rtl/axil_order_sequencer.sv
// AXI-lite master that replays queued address/data configuration orders as single writes,
// optionally holding writes to a gated address until a status register reads nonzero.
module axil_order_sequencer #(
  parameter int unsigned                 AXIL_DATA_WIDTH = 32,
  parameter int unsigned                 AXIL_ADDR_WIDTH = 8,
  parameter int unsigned                 FIFO_DEPTH      = 16,
  parameter bit                          POLL_ENABLE     = 1'b1,
  parameter logic [AXIL_ADDR_WIDTH-1:0]  GATE_ADDR       = 8'h48,
  parameter logic [AXIL_ADDR_WIDTH-1:0]  STATUS_ADDR     = 8'h4c
) (
  input  logic                         m00_axi_aclk,
  input  logic                         m00_axi_aresetn,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [AXIL_ADDR_WIDTH-1:0]   in_addr,
  input  logic [AXIL_DATA_WIDTH-1:0]   in_data,
  input  logic                         err_clr,
  output logic                         busy,
  output logic                         err,
  output logic [15:0]                  sent_count,
  output logic [AXIL_ADDR_WIDTH-1:0]   m00_axi_awaddr,
  output logic [2:0]                   m00_axi_awprot,
  output logic                         m00_axi_awvalid,
  input  logic                         m00_axi_awready,
  output logic [AXIL_DATA_WIDTH-1:0]   m00_axi_wdata,
  output logic [AXIL_DATA_WIDTH/8-1:0] m00_axi_wstrb,
  output logic                         m00_axi_wvalid,
  input  logic                         m00_axi_wready,
  input  logic [1:0]                   m00_axi_bresp,
  input  logic                         m00_axi_bvalid,
  output logic                         m00_axi_bready,
  output logic [AXIL_ADDR_WIDTH-1:0]   m00_axi_araddr,
  output logic [2:0]                   m00_axi_arprot,
  output logic                         m00_axi_arvalid,
  input  logic                         m00_axi_arready,
  input  logic [AXIL_DATA_WIDTH-1:0]   m00_axi_rdata,
  input  logic [1:0]                   m00_axi_rresp,
  input  logic                         m00_axi_rvalid,
  output logic                         m00_axi_rready
);

  localparam int unsigned STRB_W = AXIL_DATA_WIDTH / 8;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic [AXIL_ADDR_WIDTH-1:0] addr;
    logic [AXIL_DATA_WIDTH-1:0] data;
  } order_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_POLL_AR = 3'd1,
    S_POLL_R  = 3'd2,
    S_WRITE   = 3'd3,
    S_WAIT_B  = 3'd4
  } state_t;

  state_t                     r_state;
  order_t                     r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]           r_wptr;
  logic [PTR_W-1:0]           r_rptr;
  logic [CNT_W-1:0]           r_count;
  logic                       r_aw_done;
  logic                       r_w_done;
  logic                       r_busy;
  logic                       r_err;
  logic [15:0]                r_sent_count;
  logic [AXIL_ADDR_WIDTH-1:0] r_awaddr;
  logic                       r_awvalid;
  logic [AXIL_DATA_WIDTH-1:0] r_wdata;
  logic                       r_wvalid;
  logic                       r_bready;
  logic [AXIL_ADDR_WIDTH-1:0] r_araddr;
  logic                       r_arvalid;
  logic                       r_rready;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_nxt;
  order_t           w_head;
  logic             w_head_gated;
  logic             w_start_poll;
  logic             w_poll_retry;
  logic             w_start_write;
  logic             w_aw_done_nxt;
  logic             w_w_done_nxt;
  logic             w_next_idle;
  logic             w_new_err;

  assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_push       = in_valid && !w_full;
  assign w_pop        = (r_state == S_WAIT_B) && m00_axi_bvalid;
  assign w_count_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_head       = r_mem[r_rptr];
  assign w_head_gated = POLL_ENABLE && (w_head.addr == GATE_ADDR);

  // Transaction start/retry events shared by IDLE and the poll loop
  assign w_start_poll  = (r_state == S_IDLE) && !w_empty && w_head_gated;
  assign w_poll_retry  = (r_state == S_POLL_R) && m00_axi_rvalid &&
                         ((m00_axi_rresp != 2'b00) || (m00_axi_rdata == '0));
  assign w_start_write = ((r_state == S_IDLE) && !w_empty && !w_head_gated) ||
                         ((r_state == S_POLL_R) && m00_axi_rvalid &&
                          (m00_axi_rresp == 2'b00) && (m00_axi_rdata != '0));
  assign w_aw_done_nxt = r_aw_done || (r_awvalid && m00_axi_awready);
  assign w_w_done_nxt  = r_w_done || (r_wvalid && m00_axi_wready);
  assign w_next_idle   = ((r_state == S_IDLE) && w_empty) || w_pop;
  assign w_new_err     = (w_pop && (m00_axi_bresp != 2'b00)) ||
                         ((r_state == S_POLL_R) && m00_axi_rvalid && (m00_axi_rresp != 2'b00));

  // Order storage; contents need no reset since the pointers gate visibility
  always_ff @(posedge m00_axi_aclk) begin
    if (w_push) begin
      r_mem[r_wptr] <= '{addr: in_addr, data: in_data};
    end
  end

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_count <= w_count_nxt;
    end
  end

  // Sequencer FSM with registered AXI outputs and status
  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      r_state      <= S_IDLE;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_sent_count <= '0;
      r_awaddr     <= '0;
      r_awvalid    <= 1'b0;
      r_wdata      <= '0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_araddr     <= '0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
    end else begin
      r_busy <= (w_count_nxt != '0) || !w_next_idle;
      r_err  <= (r_err && !err_clr) || w_new_err;
      if (w_pop) r_sent_count <= r_sent_count + 16'd1;

      if (w_start_write) begin
        r_state   <= S_WRITE;
        r_awaddr  <= w_head.addr;
        r_wdata   <= w_head.data;
        r_awvalid <= 1'b1;
        r_wvalid  <= 1'b1;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_rready  <= 1'b0;
      end else if (w_start_poll || w_poll_retry) begin
        r_state   <= S_POLL_AR;
        r_araddr  <= STATUS_ADDR;
        r_arvalid <= 1'b1;
        r_rready  <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: ;
          S_POLL_AR: begin
            if (m00_axi_arready) begin
              r_arvalid <= 1'b0;
              r_rready  <= 1'b1;
              r_state   <= S_POLL_R;
            end
          end
          S_POLL_R: ;
          S_WRITE: begin
            r_aw_done <= w_aw_done_nxt;
            r_w_done  <= w_w_done_nxt;
            if (r_awvalid && m00_axi_awready) r_awvalid <= 1'b0;
            if (r_wvalid && m00_axi_wready)   r_wvalid  <= 1'b0;
            if (w_aw_done_nxt && w_w_done_nxt) begin
              r_bready <= 1'b1;
              r_state  <= S_WAIT_B;
            end
          end
          S_WAIT_B: begin
            if (m00_axi_bvalid) begin
              r_bready <= 1'b0;
              r_state  <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign in_ready        = !w_full;
  assign busy            = r_busy;
  assign err             = r_err;
  assign sent_count      = r_sent_count;
  assign m00_axi_awaddr  = r_awaddr;
  assign m00_axi_awprot  = 3'b000;
  assign m00_axi_awvalid = r_awvalid;
  assign m00_axi_wdata   = r_wdata;
  assign m00_axi_wstrb   = {STRB_W{1'b1}};
  assign m00_axi_wvalid  = r_wvalid;
  assign m00_axi_bready  = r_bready;
  assign m00_axi_araddr  = r_araddr;
  assign m00_axi_arprot  = 3'b000;
  assign m00_axi_arvalid = r_arvalid;
  assign m00_axi_rready  = r_rready;

endmodule

// File: tb/tb_axil_order_sequencer.sv
// Directed bench for axil_order_sequencer: behavioural AXI-lite slave plus hand-computed expectations.
module tb_axil_order_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_addr;
  logic [31:0] in_data;
  logic        err_clr;
  logic        busy;
  logic        err;
  logic [15:0] sent_count;
  logic [7:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [7:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int n_checks = 0;
  int n_errors = 0;
  int exp_sent = 0;

  // Slave knobs and transaction logs
  bit          aw_block = 1'b0;
  int          aw_delay = 0;
  int          aw_cnt   = 0;
  int          aw_pend  = 0;
  int          w_pend   = 0;
  logic [1:0]  bresp_q[$];
  logic [31:0] rdata_q[$];
  logic [7:0]  aw_log[$];
  logic [31:0] w_log[$];
  logic [7:0]  ar_log[$];
  int          aw_at_r[$];
  int          n_b   = 0;
  int          aw_hi = 0;
  int          w_hi  = 0;

  always #5 clk = ~clk;

  axil_order_sequencer dut (
    .m00_axi_aclk    (clk),
    .m00_axi_aresetn (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_addr         (in_addr),
    .in_data         (in_data),
    .err_clr         (err_clr),
    .busy            (busy),
    .err             (err),
    .sent_count      (sent_count),
    .m00_axi_awaddr  (awaddr),
    .m00_axi_awprot  (awprot),
    .m00_axi_awvalid (awvalid),
    .m00_axi_awready (awready),
    .m00_axi_wdata   (wdata),
    .m00_axi_wstrb   (wstrb),
    .m00_axi_wvalid  (wvalid),
    .m00_axi_wready  (wready),
    .m00_axi_bresp   (bresp),
    .m00_axi_bvalid  (bvalid),
    .m00_axi_bready  (bready),
    .m00_axi_araddr  (araddr),
    .m00_axi_arprot  (arprot),
    .m00_axi_arvalid (arvalid),
    .m00_axi_arready (arready),
    .m00_axi_rdata   (rdata),
    .m00_axi_rresp   (rresp),
    .m00_axi_rvalid  (rvalid),
    .m00_axi_rready  (rready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Handshakes are sampled mid-cycle; slave responses are driven 1ns after the edge
  initial begin : slave
    bit s_aw, s_w, s_b, s_ar, s_r;
    forever begin
      @(negedge clk);
      s_aw = awvalid && awready;
      s_w  = wvalid && wready;
      s_b  = bvalid && bready;
      s_ar = arvalid && arready;
      s_r  = rvalid && rready;
      if (awvalid) aw_hi++;
      if (wvalid)  w_hi++;
      if (s_aw) aw_log.push_back(awaddr);
      if (s_w)  w_log.push_back(wdata);
      if (s_ar) ar_log.push_back(araddr);
      if (s_r)  aw_at_r.push_back(aw_log.size());
      if (s_b)  n_b++;
      @(posedge clk);
      #1;
      if (s_b)  bvalid = 1'b0;
      if (s_aw) aw_pend++;
      if (s_w)  w_pend++;
      if (!bvalid && aw_pend > 0 && w_pend > 0) begin
        aw_pend--;
        w_pend--;
        bvalid = 1'b1;
        bresp  = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
      end
      if (s_r) rvalid = 1'b0;
      if (s_ar) begin
        rvalid = 1'b1;
        rresp  = 2'b00;
        rdata  = (rdata_q.size() > 0) ? rdata_q.pop_front() : 32'h1;
      end
      if (awvalid) aw_cnt++;
      else         aw_cnt = 0;
      awready = !aw_block && (aw_cnt >= aw_delay);
    end
  end

  task automatic clear_logs();
    aw_log.delete();
    w_log.delete();
    ar_log.delete();
    aw_at_r.delete();
    n_b   = 0;
    aw_hi = 0;
    w_hi  = 0;
  endtask

  // Called 1ns after an edge; returns 1ns after the accepting edge
  task automatic push(input logic [7:0] a, input logic [31:0] d, input int max_cyc, output bit ok);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    ok       = 1'b0;
    for (int c = 0; c < max_cyc && !ok; c++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    int c = 0;
    while (busy && c < max_cyc) begin
      @(posedge clk);
      #1;
      c++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    bit          ok;
    int          acc;
    int          ar_before;
    int          aw_before;
    logic [31:0] got;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_addr  = '0;
    in_data  = '0;
    err_clr  = 1'b0;
    awready  = 1'b1;
    wready   = 1'b1;
    arready  = 1'b1;
    bvalid   = 1'b0;
    bresp    = 2'b00;
    rvalid   = 1'b0;
    rresp    = 2'b00;
    rdata    = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_awvalid", 32'(awvalid), 0);
    check("rst_wvalid", 32'(wvalid), 0);
    check("rst_arvalid", 32'(arvalid), 0);
    check("rst_bready", 32'(bready), 0);
    check("rst_rready", 32'(rready), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_sent", 32'(sent_count), 0);
    check("const_prot", {26'd0, awprot, arprot}, 0);
    check("const_wstrb", 32'(wstrb), 32'hF);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single order with exact cycle latency
    clear_logs();
    push(8'h10, 32'hDEADBEEF, 10, ok);
    check("single_push", 32'(ok), 1);
    @(posedge clk); #1;
    check("single_awvalid", 32'(awvalid), 1);
    check("single_wvalid", 32'(wvalid), 1);
    check("single_awaddr", 32'(awaddr), 32'h10);
    check("single_wdata", wdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    check("single_aw_drop", 32'(awvalid), 0);
    check("single_bready", 32'(bready), 1);
    @(posedge clk); #1;
    exp_sent++;
    check("single_sent", 32'(sent_count), 32'(exp_sent));
    check("single_bready_low", 32'(bready), 0);
    check("single_busy", 32'(busy), 0);
    check("single_err", 32'(err), 0);
    check("single_nb", 32'(n_b), 1);

    // Skewed AW/W: awready after 3 cycles of awvalid
    clear_logs();
    aw_delay = 3;
    push(8'h14, 32'h0000_0A5A, 10, ok);
    wait_idle(50, "skew_idle");
    aw_delay = 0;
    exp_sent++;
    check("skew_aw_hi", 32'(aw_hi), 3);
    check("skew_w_hi", 32'(w_hi), 1);
    check("skew_nb", 32'(n_b), 1);
    check("skew_sent", 32'(sent_count), 32'(exp_sent));
    got = (w_log.size() > 0) ? w_log[0] : 32'hFFFF_FFFF;
    check("skew_wdata", got, 32'h0000_0A5A);

    // Gated write polls status until nonzero
    clear_logs();
    rdata_q = '{32'h0, 32'h0, 32'h5};
    push(8'h48, 32'h1, 10, ok);
    wait_idle(100, "gate_idle");
    exp_sent++;
    check("gate_nreads", 32'(ar_log.size()), 3);
    for (int i = 0; i < 3; i++) begin
      got = (i < ar_log.size()) ? 32'(ar_log[i]) : 32'hFFFF_FFFF;
      check($sformatf("gate_araddr%0d", i), got, 32'h4C);
      got = (i < aw_at_r.size()) ? 32'(aw_at_r[i]) : 32'hFFFF_FFFF;
      check($sformatf("gate_no_early_aw%0d", i), got, 0);
    end
    check("gate_nwrites", 32'(aw_log.size()), 1);
    got = (aw_log.size() > 0) ? 32'(aw_log[0]) : 32'hFFFF_FFFF;
    check("gate_awaddr", got, 32'h48);
    got = (w_log.size() > 0) ? w_log[0] : 32'hFFFF_FFFF;
    check("gate_wdata", got, 32'h1);
    check("gate_sent", 32'(sent_count), 32'(exp_sent));

    // Backpressure: FIFO fills at 16 while AW is stalled
    clear_logs();
    aw_block = 1'b1;
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      push(8'(8'h80 + i), 32'h1000 + 32'(i), 5, ok);
      if (ok) acc++;
    end
    push(8'h90, 32'h1010, 5, ok);
    check("bp_accepted", 32'(acc), 16);
    check("bp_17th_rejected", 32'(ok), 0);
    check("bp_in_ready", 32'(in_ready), 0);
    aw_block = 1'b0;
    for (int i = 16; i < 20; i++) begin
      push(8'(8'h80 + i), 32'h1000 + 32'(i), 100, ok);
      check($sformatf("bp_push%0d", i), 32'(ok), 1);
    end
    wait_idle(500, "bp_idle");
    exp_sent += 20;
    check("bp_nwrites", 32'(aw_log.size()), 20);
    for (int i = 0; i < 20; i++) begin
      got = (i < aw_log.size()) ? 32'(aw_log[i]) : 32'hFFFF_FFFF;
      check($sformatf("bp_addr%0d", i), got, 32'h80 + 32'(i));
      got = (i < w_log.size()) ? w_log[i] : 32'hFFFF_FFFF;
      check($sformatf("bp_data%0d", i), got, 32'h1000 + 32'(i));
    end
    check("bp_sent", 32'(sent_count), 32'(exp_sent));

    // Error response on the middle write
    clear_logs();
    bresp_q = '{2'b00, 2'b10, 2'b00};
    push(8'h20, 32'hA0, 10, ok);
    push(8'h24, 32'hA1, 10, ok);
    push(8'h28, 32'hA2, 10, ok);
    wait_idle(100, "err_idle");
    exp_sent += 3;
    check("err_set", 32'(err), 1);
    check("err_nb", 32'(n_b), 3);
    check("err_nwrites", 32'(aw_log.size()), 3);
    check("err_sent", 32'(sent_count), 32'(exp_sent));
    repeat (2) @(posedge clk);
    #1;
    check("err_held", 32'(err), 1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("err_cleared", 32'(err), 0);

    // Reset while awvalid is high abandons the write
    clear_logs();
    aw_block = 1'b1;
    push(8'h30, 32'h55, 10, ok);
    @(posedge clk); #1;
    check("rstm_awvalid_pre", 32'(awvalid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstm_awvalid", 32'(awvalid), 0);
    check("rstm_wvalid", 32'(wvalid), 0);
    check("rstm_awaddr", 32'(awaddr), 0);
    check("rstm_wdata", wdata, 0);
    check("rstm_busy", 32'(busy), 0);
    check("rstm_sent", 32'(sent_count), 0);
    check("rstm_in_ready", 32'(in_ready), 1);
    aw_pend  = 0;
    w_pend   = 0;
    bvalid   = 1'b0;
    aw_block = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    aw_before = aw_log.size();
    ar_before = ar_log.size();
    repeat (20) @(posedge clk);
    #1;
    check("rstm_no_aw", 32'(aw_log.size()), 32'(aw_before));
    check("rstm_no_ar", 32'(ar_log.size()), 32'(ar_before));
    check("rstm_no_w", 32'(w_log.size()), 0);
    check("rstm_idle_busy", 32'(busy), 0);
    check("rstm_idle_sent", 32'(sent_count), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
